// File: rtl/uart_pkg.sv
// Shared constants and types for the UART TX arbiter.
// Register offsets, CONF bit positions, AXI response codes, FSM states.
package uart_pkg;

  localparam logic [3:0] UART_DATA_OFS = 4'h0;
  localparam logic [3:0] UART_CONF_OFS = 4'h4;

  localparam int CONF_TX_EMPTY = 5;
  localparam int CONF_TX_FULL  = 4;
  localparam int CONF_RX_EMPTY = 3;
  localparam int CONF_RX_FULL  = 2;
  localparam int CONF_TX_BUSY  = 1;
  localparam int CONF_RX_BUSY  = 0;
  localparam int CONF_RX_ERR   = 31;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_CONF,
    ST_R_WAIT,
    ST_GAP,
    ST_WR,
    ST_B_WAIT,
    ST_DONE
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority picker: first active request at or after ptr_i.
// Purely combinational; lock and pointer state live in the caller.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int j;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// AXI4-Lite manager sharing one UART TX FIFO among N_REQ byte streams.
// Define UART_TXARB_TIMEOUT_EN to force-release a stalled message lock.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] UART_BASE = '0,
  parameter int POLL_GAP   = 16,
`ifdef UART_TXARB_TIMEOUT_EN
  parameter int LOCK_TIMEOUT = 1024,
`endif
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [8*N_REQ-1:0]    req_data,
  input  logic [N_REQ-1:0]      req_last,
  output logic [N_REQ-1:0]      req_ready,
  output logic [IW-1:0]         grant_id,
  output logic                  busy,
  output logic                  err,
  input  logic                  err_clr,
`ifdef UART_TXARB_TIMEOUT_EN
  output logic                  timeout_flag,
`endif
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [31:0]           m_wdata,
  output logic [3:0]            m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [31:0]           m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready
);

  localparam int GW = $clog2(POLL_GAP + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);
  localparam logic [IW-1:0] LAST_ID  = IW'(N_REQ - 1);

  arb_state_e      state_q;
  logic            lock_q;
  logic [IW-1:0]   grant_q;
  logic [IW-1:0]   rr_ptr_q;
  logic [7:0]      byte_q;
  logic            last_q;
  logic [GW-1:0]   gap_q;
  logic            arvalid_q;
  logic            rready_q;
  logic            awvalid_q;
  logic            wvalid_q;
  logic            bready_q;
  logic            err_q;

  logic [N_REQ-1:0] rr_gnt;
  logic [IW-1:0]    rr_idx;
  logic             rr_any;
  logic [IW-1:0]    next_ptr;
  logic             set_err;
  logic             aw_done;
  logic             w_done;
  logic             unused_ok;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx),
    .any_o (rr_any)
  );

  assign next_ptr = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
  assign aw_done  = !awvalid_q || m_awready;
  assign w_done   = !wvalid_q || m_wready;

  assign set_err =
    (state_q == ST_R_WAIT && m_rvalid && m_rresp != RESP_OKAY) ||
    (state_q == ST_B_WAIT && m_bvalid && m_bresp != RESP_OKAY);

  // Accept is a plain valid/ready handshake on the locked stream.
  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE && lock_q)
      req_ready[grant_q] = req_valid[grant_q];
  end

`ifdef UART_TXARB_TIMEOUT_EN
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(LOCK_TIMEOUT - 1);
  logic [TW-1:0] to_q;
  logic          to_flag_q;
  logic          starved;

  assign starved = state_q == ST_IDLE && lock_q && !req_valid[grant_q];
  assign timeout_flag = to_flag_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_q      <= '0;
      to_flag_q <= 1'b0;
    end else begin
      to_q <= (starved && to_q != TO_LAST) ? to_q + 1'b1 : '0;
      if (starved && to_q == TO_LAST) to_flag_q <= 1'b1;
      else if (err_clr)               to_flag_q <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      lock_q    <= 1'b0;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      byte_q    <= '0;
      last_q    <= 1'b0;
      gap_q     <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (set_err)      err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!lock_q) begin
            if (rr_any) begin
              lock_q  <= 1'b1;
              grant_q <= rr_idx;
            end
          end else if (req_valid[grant_q]) begin
            byte_q    <= req_data[grant_q*8 +: 8];
            last_q    <= req_last[grant_q];
            arvalid_q <= 1'b1;
            state_q   <= ST_RD_CONF;
          end
`ifdef UART_TXARB_TIMEOUT_EN
          else if (to_q == TO_LAST) begin
            lock_q   <= 1'b0;
            rr_ptr_q <= next_ptr;
          end
`endif
        end
        ST_RD_CONF: begin
          if (m_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_R_WAIT;
          end
        end
        ST_R_WAIT: begin
          if (m_rvalid) begin
            rready_q <= 1'b0;
            if (m_rresp != RESP_OKAY) begin
              state_q <= ST_DONE;
            end else if (m_rdata[CONF_TX_FULL]) begin
              gap_q   <= '0;
              state_q <= ST_GAP;
            end else begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= ST_WR;
            end
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            arvalid_q <= 1'b1;
            state_q   <= ST_RD_CONF;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        ST_WR: begin
          if (m_awready) awvalid_q <= 1'b0;
          if (m_wready)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= ST_B_WAIT;
          end
        end
        ST_B_WAIT: begin
          if (m_bvalid) begin
            bready_q <= 1'b0;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (last_q) begin
            lock_q   <= 1'b0;
            rr_ptr_q <= next_ptr;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant_id  = grant_q;
  assign busy      = lock_q || state_q != ST_IDLE;
  assign err       = err_q;
  assign m_araddr  = UART_BASE + ADDR_WIDTH'(UART_CONF_OFS);
  assign m_arvalid = arvalid_q;
  assign m_rready  = rready_q;
  assign m_awaddr  = UART_BASE + ADDR_WIDTH'(UART_DATA_OFS);
  assign m_awvalid = awvalid_q;
  assign m_wdata   = {24'h0, byte_q};
  assign m_wstrb   = 4'h1;
  assign m_wvalid  = wvalid_q;
  assign m_bready  = bready_q;

  assign unused_ok = ^{m_rdata[31:CONF_TX_FULL+1],
                       m_rdata[CONF_TX_FULL-1:0], rr_gnt};

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- AXI4-Lite manager that shares one UART peripheral's TX path between N_REQ byte-stream requesters.
- Grants one requester at a time, round-robin, and holds the grant for a whole message (until a byte with last=1).
- Per byte: reads the UART CONF register until tx_fifo_full=0, then writes the byte to the DATA register.
- Sits between on-chip message sources (logger, debug monitor, CPU mailbox) and the uart block's AXI4-Lite subordinate port.

Parameters:
- N_REQ, 4, number of requesters (1..16).
- ADDR_WIDTH, 32, AXI address width.
- UART_BASE, 32'h0, base address of the target UART.
- POLL_GAP, 16, idle cycles between a CONF read that shows TX FIFO full and the next poll (>=1).

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  requester i has a byte.
- req_data  in  8*N_REQ  byte for requester i, at bits [8i+7:8i].
- req_last  in  N_REQ  byte is the final byte of its message.
- req_ready  out  N_REQ  one-cycle accept pulse for requester i.
- grant_id  out  $clog2(N_REQ) (min 1)  currently locked requester.
- busy  out  1  a message is locked or a transfer is in flight.
- err  out  1  sticky flag: a B or R response other than OKAY was received.
- err_clr  in  1  clears err.
- m_awaddr/awvalid/awready, m_wdata(32)/wstrb(4)/wvalid/wready, m_bresp(2)/bvalid/bready, m_araddr/arvalid/arready, m_rdata(32)/rresp(2)/rvalid/rready: standard AXI4-Lite manager signals.

Behaviour:
- Reset values: all valid and ready outputs 0; req_ready=0; grant_id=0; busy=0; err=0; rr_ptr=0; state=IDLE; lock cleared.
- Reset mid-transfer abandons the transfer immediately with no completion. The subordinate must be reset together with this block.
- States:
  - IDLE:
    - If unlocked, pick the first requester at or after rr_ptr with req_valid=1 and set the lock.
    - With the lock set and that requester's valid=1: pulse its req_ready for 1 cycle and capture data/last into the hold register. Go to RD_CONF.
  - RD_CONF: drive arvalid=1, araddr=UART_BASE+4 and hold them until arready. Then go to R_WAIT.
  - R_WAIT: rready=1. On rvalid:
    - rresp!=OKAY: set err, drop the byte, go to DONE.
    - rdata[4] (tx_fifo_full)=1: go to GAP.
    - Otherwise go to WR.
  - GAP: count POLL_GAP cycles, then go to RD_CONF.
  - WR: drive awvalid and wvalid together; awaddr=UART_BASE+0, wdata={24'h0,byte}, wstrb=4'h1.
    - Drop each valid independently on its own handshake (the subordinate accepts AW and W in different cycles).
    - When both have completed, go to B_WAIT.
  - B_WAIT: bready=1. On bvalid, set err if bresp!=OKAY, then go to DONE.
  - DONE: if the held byte had last=1, clear the lock and set rr_ptr=grant+1 (mod N_REQ). Go to IDLE.
- Minimum latency from accept to the DATA write reaching the subordinate: RD_CONF(>=1)+R_WAIT(>=1)+WR(>=1) cycles. At most one outstanding transaction.
- Locked requester with req_valid=0: wait in IDLE. Other requesters are not served.
- Simultaneous valids with no lock: round-robin order starting at rr_ptr. N_REQ=1 degenerates to a pass-through.
- Accepted bytes always complete or are dropped on error; there is no retry.
- err_clr and a new error in the same cycle: set wins.
- busy=1 whenever the lock is held or state!=IDLE.
- Unused m_araddr/m_awaddr bits are held stable while the matching valid is low.

Optional Feature:
- Macro: UART_TXARB_TIMEOUT_EN.
- Defined: adds parameter LOCK_TIMEOUT (default 1024).
  - Count consecutive cycles in IDLE with the lock held and the locked requester's req_valid=0.
  - At LOCK_TIMEOUT, force-release the lock, advance rr_ptr, and set sticky output timeout_flag (cleared by err_clr).
- Undefined: the lock is held indefinitely; the timeout_flag port is absent.

Decomposition:
- Package uart_pkg:
  - UART_DATA_OFS=4'h0, UART_CONF_OFS=4'h4.
  - CONF bit indices: TX_EMPTY=5, TX_FULL=4, RX_EMPTY=3, RX_FULL=2, TX_BUSY=1, RX_BUSY=0, RX_ERR=31.
  - AXI resp codes OKAY/SLVERR.
  - Arbiter state enum.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req vector, ptr. Outputs: one-hot grant and an index.
  - Combinational priority rotate. Lock and pointer update stay in uart_tx_arbiter.

Test Plan:
1. Single requester sends "AB" (0x41, 0x42 with last on 0x42), UART FIFO not full → two CONF reads, two DATA writes in order with wdata=0x41 then 0x42; req_ready pulses twice; busy drops after the second B.
2. Req0 and req2 both valid with 3-byte messages, rr_ptr=0 → all 3 bytes of req0, then all 3 of req2, never interleaved; grant_id goes 0→2; rr_ptr ends at 3.
3. CONF rdata[4]=1 for the first 3 reads, then 0 → exactly 3 GAP periods of POLL_GAP=16 cycles, then one DATA write. No write occurs while full.
4. Subordinate stalls awready 5 cycles and wready 2 cycles independently → awvalid and wvalid each drop on their own handshake; a single B is accepted; the data byte is correct.
5. bresp=SLVERR on a DATA write → err=1; the next byte proceeds; err_clr pulse → err=0. Error and clear in the same cycle → err stays 1.
6. (UART_TXARB_TIMEOUT_EN, LOCK_TIMEOUT=8) req1 sends a byte with last=0, then goes idle while req3 is valid → after 8 idle cycles the lock releases, timeout_flag=1, and req3 is granted.
